mod_c_sched: RTL

- Round-robin scheduler that shares one combinational mod_c-style compute datapath (4-bit code in, 4-bit result out) among NUM_REQ requesters.
- Accepts one request at a time and drives the code onto the datapath. Waits LATENCY cycles, captures the result and returns it tagged with the requester ID.
- Exposes a config_pkg-style status: IDLE/BUSY/DONE/ERROR.
- Codes above MAX_CODE are rejected without using the datapath; this mirrors the decode default→ERROR.

---
 rtl/mod_c_sched.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mod_c_sched.sv
// Purpose: round-robin scheduler sharing one combinational mod_c-style compute datapath among NUM_REQ requesters.
// Latency: grant to response is LATENCY+1 cycles for legal codes and 1 cycle for illegal codes (no datapath use).
// Backpressure: a response is held in DONE/ERROR until rsp_ready; no new grant is issued while a response is pending.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   req_valid/req_code/req_ready per-requester request handshake; req_ready is a combinational one-hot grant
//   dp_c / dp_y                 code driven to and result returned from the shared datapath
//   rsp_valid/rsp_data/rsp_id/rsp_err/rsp_ready  tagged response handshake
//   state_o, err_cnt            registered FSM state and saturating illegal-request count
module mod_c_sched #(
    parameter int NUM_REQ  = 4,
    parameter int LATENCY  = 2,
    parameter int MAX_CODE = 9,
    parameter int IDW      = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [4*NUM_REQ-1:0] req_code,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [3:0]           dp_c,
    input  logic [3:0]           dp_y,
    output logic                 rsp_valid,
    output logic [3:0]           rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_err,
    input  logic                 rsp_ready,
    output logic [1:0]           state_o,
    output logic [7:0]           err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    // Counter only has to reach LATENCY-1.
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

    state_t        state;
    state_t        state_nxt;
    logic [IDW-1:0] ptr;
    logic [CW-1:0]  cnt;

    logic           found;
    logic [IDW-1:0] win;
    logic [IDW-1:0] ptr_nxt;
    logic [3:0]     win_code;
    logic           code_bad;
    int             idx;

    // First valid requester searching upward from the pointer, with wrap.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        if (state == IDLE && !rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(ptr) + k) % NUM_REQ;
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    win   = IDW'(idx);
                end
            end
        end
    end

    assign req_ready = found ? (NUM_REQ'(1) << win) : '0;
    assign win_code  = req_code[{win, 2'b00} +: 4];
    assign code_bad  = int'(win_code) > MAX_CODE;
    assign ptr_nxt   = IDW'((int'(win) + 1) % NUM_REQ);
    assign rsp_valid = (state == DONE) || (state == ERROR);
    assign state_o   = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = code_bad ? ERROR : BUSY;
            BUSY:    if (cnt == CNT_LAST) state_nxt = DONE;
            DONE,
            ERROR:   if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            dp_c     <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
            rsp_err  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (found) begin
                        ptr    <= ptr_nxt;
                        rsp_id <= win;
                        if (code_bad) begin
                            // Illegal code never touches the datapath; dp_c keeps the last legal code.
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                        end else begin
                            dp_c <= win_code;
                            cnt  <= '0;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        rsp_data <= dp_y;
                        rsp_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
